// File: rtl/store_unit_if.sv
// Store unit bus bundle: launch inputs from the execute stage, status back,
// and the single-beat write channel to data memory.
interface store_unit_if;
    logic        start;
    logic [31:0] base;
    logic [31:0] ext_imm;
    logic [31:0] rt_data;
    logic [1:0]  size;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic        busy;
    logic        done;
    logic        err;

    // Requester side: execute stage plus the memory's ack.
    modport master (
        output start, base, ext_imm, rt_data, size, mem_ack,
        input  mem_req, mem_addr, mem_wdata, mem_be, busy, done, err
    );

    // Store unit side.
    modport slave (
        input  start, base, ext_imm, rt_data, size, mem_ack,
        output mem_req, mem_addr, mem_wdata, mem_be, busy, done, err
    );
endinterface

// File: rtl/store_unit.sv
// Store unit: effective address generation, byte/half/word narrowing with
// lane replication and byte enables, and one req/ack write to data memory
// with misalignment and ack-timeout error reporting.
module store_unit #(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input logic         clk,
    input logic         rst_n,
    store_unit_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StWait, StDone, StErr} state_e;

    localparam logic [7:0] LastCnt = 8'(ACK_TIMEOUT - 1);

    state_e      state_q;
    logic [7:0]  cnt_q;

    logic [31:0] ea;
    logic        bad;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_be;

    // Effective address and lane placement from the live (unregistered) inputs.
    always_comb begin
        ea         = bus.base + bus.ext_imm;
        bad        = 1'b0;
        lane_wdata = '0;
        lane_be    = '0;
        unique case (bus.size)
            2'b00: begin
                lane_wdata = {4{bus.rt_data[7:0]}};
                lane_be    = 4'b0001 << ea[1:0];
            end
            2'b01: begin
                bad        = ea[0];
                lane_wdata = {2{bus.rt_data[15:0]}};
                lane_be    = ea[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                bad        = (ea[1:0] != 2'b00);
                lane_wdata = bus.rt_data;
                lane_be    = 4'b1111;
            end
            default: begin
                bad = 1'b1;
            end
        endcase
    end

    // Transaction FSM; every output is a register written on state entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_be    <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
            unique case (state_q)
                // The DONE/ERR cycle is the last cycle of a transaction, so a
                // start on its closing edge launches the next one directly.
                StIdle, StDone, StErr: begin
                    state_q  <= StIdle;
                    bus.busy <= 1'b0;
                    if (bus.start) begin
                        bus.busy <= 1'b1;
                        if (bad) begin
                            state_q  <= StErr;
                            bus.done <= 1'b1;
                            bus.err  <= 1'b1;
                        end else begin
                            state_q       <= StWait;
                            cnt_q         <= '0;
                            bus.mem_req   <= 1'b1;
                            bus.mem_addr  <= {ea[31:2], 2'b00};
                            bus.mem_wdata <= lane_wdata;
                            bus.mem_be    <= lane_be;
                        end
                    end
                end
                StWait: begin
                    // Ack takes priority over a coincident timeout.
                    if (bus.mem_ack || (cnt_q == LastCnt)) begin
                        state_q       <= bus.mem_ack ? StDone : StErr;
                        bus.done      <= 1'b1;
                        bus.err       <= !bus.mem_ack;
                        bus.mem_req   <= 1'b0;
                        bus.mem_addr  <= '0;
                        bus.mem_wdata <= '0;
                        bus.mem_be    <= '0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_unit.sv
// Bench for store_unit: scoreboard of expected bus beats and completion
// status, pushed at launch and consumed by a negedge monitor.
module tb_store_unit;

    localparam int unsigned Timeout = 16;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    store_unit_if bus ();

    store_unit #(.ACK_TIMEOUT(Timeout)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   req_cnt  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Reference model; a timed-out store still shows its beat on the bus.
    function automatic exp_t model(input logic [31:0] b, input logic [31:0] i,
                                   input logic [31:0] d, input logic [1:0] sz,
                                   input bit to);
        logic [31:0] ea;
        exp_t        e;
        ea = b + i;
        e  = '0;
        case (sz)
            2'd0: begin
                e.wdata = {d[7:0], d[7:0], d[7:0], d[7:0]};
                case (ea[1:0])
                    2'd0: e.be = 4'b0001;
                    2'd1: e.be = 4'b0010;
                    2'd2: e.be = 4'b0100;
                    default: e.be = 4'b1000;
                endcase
            end
            2'd1: begin
                e.err   = ea[0];
                e.wdata = {d[15:0], d[15:0]};
                e.be    = ea[1] ? 4'b1100 : 4'b0011;
            end
            2'd2: begin
                e.err   = (ea[1:0] != 2'd0);
                e.wdata = d;
                e.be    = 4'b1111;
            end
            default: e.err = 1'b1;
        endcase
        e.addr = ea & 32'hFFFF_FFFC;
        if (e.err) begin
            e.addr  = '0;
            e.wdata = '0;
            e.be    = '0;
        end else if (to) begin
            e.err = 1'b1;
        end
        return e;
    endfunction

    // Monitor: bus beat vs scoreboard head, idle bus zero, done/err pairing.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_req) begin
                req_cnt++;
                if (exp_q.size() == 0) begin
                    chk("req_spurious", 1, 0);
                end else begin
                    chk("mem_addr", bus.mem_addr, exp_q[0].addr);
                    chk("mem_wdata", bus.mem_wdata, exp_q[0].wdata);
                    chk("mem_be", bus.mem_be, exp_q[0].be);
                end
            end else begin
                chk("idle_addr", bus.mem_addr, 0);
                chk("idle_wdata_be", {bus.mem_wdata, bus.mem_be}, 0);
            end
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    chk("done_spurious", 1, 0);
                end else begin
                    chk("err_flag", bus.err, exp_q[0].err);
                    void'(exp_q.pop_front());
                end
            end else begin
                chk("err_without_done", bus.err, 0);
            end
        end
    end

    // Launch at the current negedge; k = ack edge after start (0 = never ack).
    // Returns at the negedge on which done is expected.
    task automatic do_store(input logic [31:0] b, input logic [31:0] i, input logic [31:0] d,
                            input logic [1:0] sz, input int k, input bit disturb);
        exp_t e;
        bit   bad;
        int   r0;
        int   w;
        e   = model(b, i, d, sz, 1'b0);
        bad = e.err;
        e   = model(b, i, d, sz, k == 0);
        bus.base    = b;
        bus.ext_imm = i;
        bus.rt_data = d;
        bus.size    = sz;
        bus.start   = 1'b1;
        exp_q.push_back(e);
        r0 = req_cnt;
        @(negedge clk);
        bus.start = 1'b0;
        if (!bad && k > 0) begin
            for (int c = 0; c < k - 1; c++) begin
                if (disturb && c == 1) begin
                    bus.start   = 1'b1;
                    bus.base    = ~b;
                    bus.ext_imm = 32'h4;
                    bus.rt_data = ~d;
                    bus.size    = 2'b10;
                end else begin
                    bus.start = 1'b0;
                end
                @(negedge clk);
            end
            bus.mem_ack = 1'b1;
            @(negedge clk);
            bus.mem_ack = 1'b0;
            bus.start   = 1'b0;
        end
        w = 0;
        while (!bus.done && w < 64) begin
            @(negedge clk);
            w++;
        end
        chk("done_seen", bus.done, 1);
        if (k > 0 || bad) chk("done_latency", w, 0);
        chk("busy_at_done", bus.busy, 1);
        chk("req_at_done", bus.mem_req, 0);
        if (bad) chk("misalign_req_cycles", req_cnt - r0, 0);
        else if (k == 0) chk("timeout_req_cycles", req_cnt - r0, Timeout);
        else chk("req_cycles", req_cnt - r0, k);
    endtask

    task automatic settle();
        @(negedge clk);
        chk("idle_busy", bus.busy, 0);
        chk("idle_done", bus.done, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.start   = 1'b0;
        bus.base    = '0;
        bus.ext_imm = '0;
        bus.rt_data = '0;
        bus.size    = '0;
        bus.mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {bus.mem_req, bus.busy, bus.done, bus.err, bus.mem_be}, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        do_store(32'h0000_1000, 32'hFFFF_FFFF, 32'h1234_56AB, 2'b00, 3, 0); settle();
        do_store(32'h0000_2000, 32'h0000_0006, 32'hCAFE_BEEF, 2'b01, 2, 0); settle();
        do_store(32'h0000_2000, 32'h0000_0003, 32'hCAFE_BEEF, 2'b01, 1, 0);
        chk("misalign_err", bus.err, 1);
        settle();
        do_store(32'hFFFF_FFFC, 32'h0000_0008, 32'hDEAD_BEEF, 2'b10, 1, 0); settle();
        do_store(32'h0000_0100, 32'h0000_0000, 32'hDEAD_BEEF, 2'b11, 1, 0); settle();
        do_store(32'h0000_0100, 32'h0000_0002, 32'hDEAD_BEEF, 2'b10, 1, 0); settle();
        for (int o = 0; o < 4; o++) begin
            do_store(32'h0000_0040, 32'(o), 32'h8765_4321, 2'b00, 1, 0); settle();
        end
        do_store(32'h0000_0040, 32'h0000_0000, 32'h8765_4321, 2'b01, 2, 0); settle();

        // Ack outside WAIT is ignored.
        bus.mem_ack = 1'b1;
        repeat (2) @(negedge clk);
        bus.mem_ack = 1'b0;

        // Timeout, and ack exactly on the timeout edge.
        do_store(32'h0000_3000, 32'h0000_0010, 32'h0BAD_F00D, 2'b10, 0, 0); settle();
        do_store(32'h0000_3000, 32'h0000_0010, 32'h0BAD_F00D, 2'b10, Timeout, 0); settle();

        // Start and input changes during WAIT are ignored.
        do_store(32'h0000_4000, 32'h0000_0004, 32'h1111_2222, 2'b10, 5, 1);
        repeat (3) settle();

        // Back-to-back: new start on the done cycle.
        do_store(32'h0000_5000, 32'h0000_0001, 32'hA5A5_5A5A, 2'b00, 1, 0);
        do_store(32'h0000_5000, 32'h0000_0008, 32'h3C3C_C3C3, 2'b10, 2, 0);
        settle();

        // Reset in the second WAIT cycle abandons the request silently.
        bus.base    = 32'h0000_6000;
        bus.ext_imm = 32'h0000_0000;
        bus.rt_data = 32'h7777_8888;
        bus.size    = 2'b10;
        bus.start   = 1'b1;
        exp_q.push_back(model(32'h0000_6000, 32'h0, 32'h7777_8888, 2'b10, 1'b0));
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_ctrl", {bus.mem_req, bus.busy, bus.done, bus.err, bus.mem_be}, 0);
        chk("midrst_addr", bus.mem_addr, 0);
        chk("midrst_wdata", bus.mem_wdata, 0);
        exp_q.delete();
        rst_n = 1'b1;
        @(negedge clk);
        do_store(32'h0000_6000, 32'h0000_0002, 32'h7777_8888, 2'b01, 2, 0); settle();

        // Randomised mix, including illegal and misaligned ones.
        for (int n = 0; n < 16; n++) begin
            logic [31:0] b;
            logic [31:0] i;
            b = $urandom;
            i = 32'($urandom_range(0, 15)) - 32'd8;
            do_store(b, i, $urandom, 2'($urandom_range(0, 3)), $urandom_range(1, 4), 0);
            settle();
        end

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/store_unit.md
# store_unit

Store-side memory write unit for the execution-cycle datapath: the write-direction counterpart of the load path's immediate sign-extension and data widening. On `start` it computes the effective address from `base` plus the 32-bit sign-extended immediate, then narrows `rt_data` to byte, halfword or word. It lane-aligns the data with byte enables and performs a single req/ack write transaction to data memory. Misaligned requests and unanswered requests are reported as errors.

## Interface
- `ACK_TIMEOUT`, default 16: max cycles `mem_req` stays high without `mem_ack` before abort; legal range 2..255.

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, synchronous and active-low
- `start`  in  1  launch a store; sampled only in IDLE
- `base`  in  32  base register value (rs)
- `ext_imm`  in  32  sign-extended offset from the sign extender
- `rt_data`  in  32  register data to store
- `size`  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- `mem_req`  out  1  write request, held until ack or timeout
- `mem_addr`  out  32  word-aligned address {ea[31:2],2'b00}
- `mem_wdata`  out  32  lane-replicated write data
- `mem_be`  out  4  byte enables, bit i = byte lane i (bits 8i+7:8i)
- `mem_ack`  in  1  memory accepted the write
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  one-cycle error pulse, coincident with `done`

## Operation
- States: IDLE, WAIT, DONE, ERR.
- IDLE with `start`=1:
  - register ea = base + ext_imm, modulo 2^32, carry discarded.
  - register size and rt_data.
  - decide the next state combinationally from the unregistered ea.
- Misaligned or illegal start goes to ERR, with no memory request. This covers size=11, halfword with ea[0]=1, and word with ea[1:0]≠00.
- Any other start goes to WAIT.
- Lane mapping:
  - byte: wdata={4{rt[7:0]}}, be=4'b0001<<ea[1:0].
  - half: wdata={2{rt[15:0]}}, be = ea[1] ? 1100 : 0011.
  - word: wdata=rt, be=1111.
- WAIT:
  - `mem_req`=1; `mem_addr`, `mem_wdata` and `mem_be` are stable for the whole state.
  - A cycle counter starts at 0 on entry and increments each WAIT cycle.
  - `mem_ack`=1 on a rising edge goes to DONE.
  - Otherwise, counter = ACK_TIMEOUT-1 goes to ERR.
  - `mem_ack` wins if it arrives on the same edge as the timeout.
- DONE: `done`=1 for one cycle, then IDLE.
- ERR: `done`=1 and `err`=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored, with no queuing. `mem_ack` outside WAIT is ignored.
- Input changes after the start edge have no effect on the transaction in flight.
- All outputs are registered. `mem_addr`, `mem_wdata` and `mem_be` are 0 whenever `mem_req`=0.

## Timing
- Reset (`rst_n`=0 on a rising edge): state IDLE, counter 0. Every output is 0: `mem_req`, `mem_addr`, `mem_wdata`, `mem_be`, `busy`, `done`, `err`.
- Reset mid-WAIT: `mem_req` drops at that edge, with no `done` or `err`. The memory side must tolerate an abandoned request.
- Normal store with start sampled at edge 0:
  - `mem_req` and `busy` are high after edge 0.
  - If `mem_ack` is sampled high at edge k≥1, `mem_req` is low and `done` is high after edge k.
  - `busy` drops and IDLE is reached after edge k+1.
  - A new `start` is accepted at edge k+1.
  - Minimum start-to-done is 2 edges; minimum start-to-start throughput is 2 cycles.
- Misaligned store: `done`, `err` and `busy` are high after edge 0 and low after edge 1; `mem_req` never rises.
- Timeout: with no ack, `mem_req` is high for exactly ACK_TIMEOUT cycles. `err`/`done` pulse on the following cycle.

## Test plan
- SB: base=0x1000, ext_imm=0xFFFFFFFF (−1), rt=0x123456AB, size=00 → mem_addr=0x00000FFC, be=1000, wdata=0xABABABAB. Ack after 3 cycles → one `done` pulse, err=0.
- SH: base=0x2000, ext_imm=0x00000006, rt=0xCAFEBEEF → mem_addr=0x2004, be=1100, wdata=0xBEEFBEEF. Also ea=0x2003 → err pulse, mem_req stays 0.
- SW: base=0xFFFFFFFC, ext_imm=0x00000008 (wraps) → mem_addr=0x00000004, be=1111, wdata=rt. Also size=11 → err.
- Timeout: SW with mem_ack held 0, ACK_TIMEOUT=16 → mem_req high exactly 16 cycles, then done=err=1 for one cycle. Also ack on cycle 16 → done, err=0.
- Protocol: `start` pulsed during WAIT is ignored (exactly one transaction), and inputs changed mid-WAIT leave wdata and addr unchanged. Back-to-back start on the cycle after `done` is accepted.
- Reset: rst_n=0 in the second WAIT cycle → all outputs 0 after that edge, no done. Next start completes normally.
